// File: rtl/commit_ctrl_pkg.sv
// Shared encodings for the in-order commit sequencer.
package commit_ctrl_pkg;

  localparam int unsigned ROB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    TYPE_REG   = 2'd0,
    TYPE_CTRL  = 2'd1,
    TYPE_STORE = 2'd2,
    TYPE_HALT  = 2'd3
  } head_type_e;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_STORE_WAIT = 3'd1,
    ST_REDIRECT   = 3'd2,
    ST_FLUSH      = 3'd3,
    ST_HALTED     = 3'd4
  } commit_state_e;

endpackage

// File: rtl/commit_ctrl.sv
// ROB-head commit sequencer: retires entries in order, holds stores for memory
// acknowledgement, and orders a mispredict's rd write-back ahead of the flush.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [1:0]           head_type,
  input  logic [4:0]           head_rd_id,
  input  logic [31:0]          head_value,
  input  logic [ROB_WIDTH-1:0] head_tag,
  input  logic                 head_mispredict,
  input  logic [31:0]          head_target_pc,
  output logic                 head_pop,
  output logic                 rob_commit_signal,
  output logic [31:0]          commit_rd_value,
  output logic [4:0]           commit_rd_id,
  output logic [ROB_WIDTH-1:0] commit_rd_tag,
  output logic                 clear_signal,
  output logic [31:0]          redirect_pc,
  output logic                 store_req,
  output logic [ROB_WIDTH-1:0] store_tag,
  input  logic                 store_ack,
  output logic                 halt_out,
  output logic [31:0]          commit_count
);

  commit_state_e        r_state, w_state_nxt;
  logic [31:0]          r_target, w_target_nxt;
  logic                 w_commit_nxt;
  logic [31:0]          w_value_nxt;
  logic [4:0]           w_id_nxt;
  logic [ROB_WIDTH-1:0] w_tag_nxt;
  logic                 w_clear_nxt;
  logic [31:0]          w_redirect_nxt;
  logic                 w_store_req_nxt;
  logic [ROB_WIDTH-1:0] w_store_tag_nxt;
  logic                 w_halt_nxt;
  logic                 w_head_go;
  head_type_e           w_type;

  assign w_type    = head_type_e'(head_type);
  assign w_head_go = head_valid && head_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_RUN;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    head_pop        = 1'b0;
    w_commit_nxt    = rob_commit_signal;
    w_value_nxt     = commit_rd_value;
    w_id_nxt        = commit_rd_id;
    w_tag_nxt       = commit_rd_tag;
    w_clear_nxt     = clear_signal;
    w_redirect_nxt  = redirect_pc;
    w_store_req_nxt = store_req;
    w_store_tag_nxt = store_tag;
    w_halt_nxt      = halt_out;
    // With rdy_in low every register, including the pulses, simply holds.
    if (rdy_in) begin
      w_commit_nxt = 1'b0;
      w_clear_nxt  = 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (w_head_go) begin
            unique case (w_type)
              TYPE_REG, TYPE_CTRL: begin
                head_pop     = 1'b1;
                w_commit_nxt = (w_type == TYPE_REG) || (head_rd_id != 5'd0);
                w_value_nxt  = head_value;
                w_id_nxt     = head_rd_id;
                w_tag_nxt    = head_tag;
                if (w_type == TYPE_CTRL && head_mispredict) begin
                  w_target_nxt = head_target_pc;
                  w_state_nxt  = ST_REDIRECT;
                end
              end
              TYPE_STORE: begin
                w_store_req_nxt = 1'b1;
                w_store_tag_nxt = head_tag;
                w_state_nxt     = ST_STORE_WAIT;
              end
              TYPE_HALT: begin
                head_pop    = 1'b1;
                w_halt_nxt  = 1'b1;
                w_state_nxt = ST_HALTED;
              end
              default: ;
            endcase
          end
        end
        ST_STORE_WAIT: begin
          if (store_ack) begin
            head_pop        = 1'b1;
            w_store_req_nxt = 1'b0;
            w_state_nxt     = ST_RUN;
          end
        end
        ST_REDIRECT: begin
          w_clear_nxt    = 1'b1;
          w_redirect_nxt = r_target;
          w_state_nxt    = ST_FLUSH;
        end
        ST_FLUSH:  w_state_nxt = ST_RUN;
        ST_HALTED: ;
        default:   w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_target          <= '0;
      rob_commit_signal <= 1'b0;
      commit_rd_value   <= '0;
      commit_rd_id      <= '0;
      commit_rd_tag     <= '0;
      clear_signal      <= 1'b0;
      redirect_pc       <= '0;
      store_req         <= 1'b0;
      store_tag         <= '0;
      halt_out          <= 1'b0;
      commit_count      <= '0;
    end else begin
      r_target          <= w_target_nxt;
      rob_commit_signal <= w_commit_nxt;
      commit_rd_value   <= w_value_nxt;
      commit_rd_id      <= w_id_nxt;
      commit_rd_tag     <= w_tag_nxt;
      clear_signal      <= w_clear_nxt;
      redirect_pc       <= w_redirect_nxt;
      store_req         <= w_store_req_nxt;
      store_tag         <= w_store_tag_nxt;
      halt_out          <= w_halt_nxt;
      if (head_pop) commit_count <= commit_count + 32'd1;
    end
  end

endmodule
